// File: rtl/sd_spi_responder_if.sv
// SPI pins plus the byte-wide backing-store port of the SD responder.
//   spi_clk/cs/mosi : from the SPI master (asynchronous to the system clock)
//   miso            : responder data, MSB first
//   mem_*           : block/offset address, read strobe/data, write strobe/data
//   initialized     : card left idle via ACMD41
// master = SPI host + memory model side, slave = the responder.
interface sd_spi_responder_if;
  logic        spi_clk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [31:0] mem_block;
  logic [8:0]  mem_offset;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        initialized;

  modport master (
    output spi_clk, cs, mosi, mem_rdata,
    input  miso, mem_block, mem_offset, mem_re, mem_we, mem_wdata, initialized
  );
  modport slave (
    input  spi_clk, cs, mosi, mem_rdata,
    output miso, mem_block, mem_offset, mem_re, mem_we, mem_wdata, initialized
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card target. Oversamples spi_clk/cs/mosi in the clk domain,
// decodes 48-bit command frames and answers with R1/R3/R7. Serves CMD17
// single-block reads from and CMD24 single-block writes to a byte store.
//   clk, rst : system clock (>= 4x spi_clk), synchronous active-high reset
//   bus      : sd_spi_responder_if.slave (SPI pins + memory port)
module sd_spi_responder #(
  parameter int ACMD41_RETRIES = 2,
  parameter int NAC_BYTES      = 4,
  parameter int BUSY_BYTES     = 8
) (
  input logic               clk,
  input logic               rst,
  sd_spi_responder_if.slave bus
);
  localparam logic [7:0] ACMD_MAX  = 8'(ACMD41_RETRIES);
  localparam logic [7:0] NAC_LAST  = 8'(NAC_BYTES - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_BYTES - 1);

  typedef enum logic [3:0] {
    HUNT, CMD, GAP, RESP, NAC, TOKEN, RDATA, RCRC,
    WTOKEN, WDATA, WCRC, DRESP, BUSY
  } state_t;

  state_t      state, resp_next;
  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_d;
  logic        sclk_rise, sclk_fall, cs_hi, mosi_s;

  logic [45:0] cmd_sh;      // start bit falls off the top; [45] is the tx bit
  logic [5:0]  frm_cnt;
  logic [6:0]  rx_sh;
  logic [2:0]  rx_cnt;
  logic [6:0]  tx_sh;
  logic [2:0]  tx_cnt;      // bits of the current byte still to shift out
  logic [39:0] resp_sh;     // queued response bytes, first byte in [39:32]
  logic [2:0]  resp_left;
  logic [7:0]  cnt, acmd_cnt, rd_byte;
  logic        app, re_q;
  logic        miso_q, mem_re_q, mem_we_q, init_q;
  logic [31:0] mem_block_q;
  logic [8:0]  mem_offset_q;
  logic [7:0]  mem_wdata_q;

  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [7:0]  cmd_crc, idle_r1, rx_byte, tx_byte;
  logic        tx_has;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_hi     = cs_sync[1];
  assign mosi_s    = mosi_sync[1];

  // Frame fields, valid while the 48th bit is on mosi_s.
  assign cmd_idx = cmd_sh[44:39];
  assign cmd_arg = cmd_sh[38:7];
  assign cmd_crc = {cmd_sh[6:0], mosi_s};
  assign idle_r1 = {7'd0, ~init_q};
  assign rx_byte = {rx_sh, mosi_s};

  assign bus.miso        = miso_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_block   = mem_block_q;
  assign bus.mem_offset  = mem_offset_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.initialized = init_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.spi_clk};
      cs_sync   <= {cs_sync[0], bus.cs};
      mosi_sync <= {mosi_sync[0], bus.mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  // Byte to present at the start of the next byte slot; only the
  // transmitting states have one, everything else idles miso high.
  always_comb begin
    tx_byte = 8'hFF;
    tx_has  = 1'b1;
    case (state)
      GAP, NAC, RCRC: tx_byte = 8'hFF;
      RESP:           tx_byte = resp_sh[39:32];
      TOKEN:          tx_byte = 8'hFE;
      RDATA:          tx_byte = rd_byte;
      DRESP:          tx_byte = 8'h05;
      BUSY:           tx_byte = 8'h00;
      default:        tx_has  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      resp_next    <= HUNT;
      cmd_sh       <= '0;
      frm_cnt      <= '0;
      rx_sh        <= '0;
      rx_cnt       <= '0;
      tx_sh        <= '1;
      tx_cnt       <= '0;
      resp_sh      <= '1;
      resp_left    <= '0;
      cnt          <= '0;
      acmd_cnt     <= '0;
      rd_byte      <= '0;
      app          <= 1'b0;
      re_q         <= 1'b0;
      miso_q       <= 1'b1;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      init_q       <= 1'b0;
      mem_block_q  <= '0;
      mem_offset_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      re_q     <= mem_re_q;
      if (re_q) rd_byte <= bus.mem_rdata;
      // Write offset advances the cycle after the strobe so the store
      // sees the offset of the byte being written.
      if (mem_we_q) mem_offset_q <= mem_offset_q + 9'd1;

      if (cs_hi) begin
        state  <= HUNT;
        tx_cnt <= '0;
        miso_q <= 1'b1;
      end else if (sclk_rise) begin
        case (state)
          HUNT: if (!mosi_s) begin
            cmd_sh  <= {cmd_sh[44:0], 1'b0};
            frm_cnt <= 6'd1;
            state   <= CMD;
          end
          CMD: if (frm_cnt != 6'd47) begin
            cmd_sh  <= {cmd_sh[44:0], mosi_s};
            frm_cnt <= frm_cnt + 6'd1;
          end else if (!cmd_sh[45]) begin
            state <= HUNT;
          end else begin
            state     <= GAP;
            app       <= 1'b0;
            resp_next <= HUNT;
            resp_left <= 3'd0;
            cnt       <= '0;
            rx_cnt    <= '0;
            resp_sh   <= {idle_r1 | 8'h04, 32'hFFFF_FFFF};
            case (cmd_idx)
              6'd0: if (cmd_crc != 8'h95) resp_sh <= {idle_r1 | 8'h08, 32'hFFFF_FFFF};
                    else begin
                      init_q   <= 1'b0;
                      acmd_cnt <= '0;
                      resp_sh  <= {8'h01, 32'hFFFF_FFFF};
                    end
              6'd8: if (cmd_crc != 8'h87) resp_sh <= {idle_r1 | 8'h08, 32'hFFFF_FFFF};
                    else begin
                      resp_sh   <= {idle_r1, 24'h00_0001, cmd_arg[7:0]};
                      resp_left <= 3'd4;
                    end
              6'd55: begin
                resp_sh <= {idle_r1, 32'hFFFF_FFFF};
                app     <= 1'b1;
              end
              6'd41: if (app) begin
                if (acmd_cnt < ACMD_MAX) begin
                  acmd_cnt <= acmd_cnt + 8'd1;
                  resp_sh  <= {8'h01, 32'hFFFF_FFFF};
                end else begin
                  init_q  <= 1'b1;
                  resp_sh <= {8'h00, 32'hFFFF_FFFF};
                end
              end
              6'd58: begin
                resp_sh   <= {idle_r1, 32'hC0FF_8000};
                resp_left <= 3'd4;
              end
              6'd17, 6'd24: if (!init_q) resp_sh <= {8'h05, 32'hFFFF_FFFF};
                else begin
                  resp_sh     <= {8'h00, 32'hFFFF_FFFF};
                  mem_block_q <= cmd_arg;
                  resp_next   <= (cmd_idx == 6'd17) ? NAC : WTOKEN;
                end
              default: ;
            endcase
          end
          WTOKEN, WDATA, WCRC: begin
            rx_sh  <= rx_byte[6:0];
            rx_cnt <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd7) begin
              case (state)
                WTOKEN: if (rx_byte == 8'hFE) begin
                  state        <= WDATA;
                  mem_offset_q <= '0;
                end
                WDATA: begin
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= rx_byte;
                  if (mem_offset_q == 9'd511) begin
                    state <= WCRC;
                    cnt   <= '0;
                  end
                end
                default: begin
                  cnt <= cnt + 8'd1;
                  if (cnt == 8'd1) state <= DRESP;
                end
              endcase
            end
          end
          default: ;
        endcase
      end else if (sclk_fall) begin
        if (tx_cnt != 3'd0) begin
          miso_q <= tx_sh[6];
          tx_sh  <= {tx_sh[5:0], 1'b1};
          tx_cnt <= tx_cnt - 3'd1;
        end else if (tx_has) begin
          miso_q <= tx_byte[7];
          tx_sh  <= tx_byte[6:0];
          tx_cnt <= 3'd7;
          case (state)
            GAP: state <= RESP;
            RESP: begin
              resp_sh <= {resp_sh[31:0], 8'hFF};
              if (resp_left == 3'd0) state <= resp_next;
              else resp_left <= resp_left - 3'd1;
            end
            NAC: if (cnt == NAC_LAST) begin
              // First read goes out here so byte 0 is ready for RDATA.
              state        <= TOKEN;
              mem_offset_q <= '0;
              mem_re_q     <= 1'b1;
            end else cnt <= cnt + 8'd1;
            TOKEN: state <= RDATA;
            RDATA: begin
              mem_offset_q <= mem_offset_q + 9'd1;
              if (mem_offset_q == 9'd511) begin
                state <= RCRC;
                cnt   <= '0;
              end else mem_re_q <= 1'b1;
            end
            RCRC: if (cnt == 8'd1) state <= HUNT;
                  else cnt <= cnt + 8'd1;
            DRESP: begin
              state <= BUSY;
              cnt   <= '0;
            end
            default: if (cnt == BUSY_LAST) state <= HUNT;
                     else cnt <= cnt + 8'd1;
          endcase
        end else begin
          miso_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          re_cnt = 0, re_bad = 0, we_cnt = 0, we_bad = 0;
  logic [8:0]  re_next = '0, we_next = '0;
  logic [31:0] exp_blk = '0;
  logic [7:0]  dummy;

  sd_spi_responder_if bus();

  sd_spi_responder #(.ACMD41_RETRIES(2), .NAC_BYTES(4), .BUSY_BYTES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Backing store: byte at offset o reads as o[7:0]; writes are checked
  // against the expected i^0x5A pattern and in-order offsets.
  always @(posedge clk) begin
    if (bus.mem_re) begin
      bus.mem_rdata <= bus.mem_offset[7:0];
      re_cnt        <= re_cnt + 1;
      if ((bus.mem_offset != re_next && bus.mem_offset != 9'd0) || bus.mem_block != exp_blk)
        re_bad <= re_bad + 1;
      re_next <= bus.mem_offset + 9'd1;
    end
    if (bus.mem_we) begin
      we_cnt <= we_cnt + 1;
      if (bus.mem_offset != we_next || bus.mem_wdata != (we_next[7:0] ^ 8'h5A) ||
          bus.mem_block != exp_blk)
        we_bad <= we_bad + 1;
      we_next <= we_next + 9'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode 0 bit: mosi changes with the falling edge, miso sampled on rise.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      #30 bus.spi_clk = 1'b1;
      rx[i] = bus.miso;
      #20 bus.spi_clk = 1'b0;
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    xfer(8'hFF, r);
    chk(tag, 32'(r), 32'(exp));
  endtask

  task automatic send(input logic [47:0] f);
    for (int b = 5; b >= 0; b--) xfer(f[b*8 +: 8], dummy);
  endtask

  initial begin
    int snap;
    bus.spi_clk = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b1;
    #100;
    chk("rst_miso",   32'(bus.miso), 32'd1);
    chk("rst_re",     32'(bus.mem_re), 32'd0);
    chk("rst_we",     32'(bus.mem_we), 32'd0);
    chk("rst_block",  bus.mem_block, 32'd0);
    chk("rst_offset", 32'(bus.mem_offset), 32'd0);
    chk("rst_wdata",  32'(bus.mem_wdata), 32'd0);
    chk("rst_init",   32'(bus.initialized), 32'd0);
    rst = 1'b0;
    #20 bus.cs = 1'b0;
    #40;

    send(48'h40_0000_0000_95);
    rd("cmd0_gap", 8'hFF); rd("cmd0_r1", 8'h01);
    chk("cmd0_init", 32'(bus.initialized), 32'd0);

    send(48'h48_0000_01AA_87);
    rd("cmd8_gap", 8'hFF); rd("cmd8_r1", 8'h01); rd("cmd8_b1", 8'h00);
    rd("cmd8_b2", 8'h00);  rd("cmd8_b3", 8'h01); rd("cmd8_echo", 8'hAA);
    send(48'h48_0000_01AA_00);
    rd("cmd8crc_gap", 8'hFF); rd("cmd8crc_r1", 8'h09);

    // tx bit clear: silently discarded, miso stays high
    send(48'h08_0000_0000_95);
    rd("txzero_a", 8'hFF); rd("txzero_b", 8'hFF);

    // ACMD41 without a preceding CMD55 is just an illegal index
    send(48'h69_4000_0000_FF);
    rd("acmd_noapp_gap", 8'hFF); rd("acmd_noapp_r1", 8'h05);

    send(48'h77_0000_0000_FF); rd("cmd55a_gap", 8'hFF); rd("cmd55a_r1", 8'h01);
    send(48'h69_4000_0000_FF); rd("acmd41a_gap", 8'hFF); rd("acmd41a_r1", 8'h01);
    chk("acmd41a_init", 32'(bus.initialized), 32'd0);
    send(48'h77_0000_0000_FF); rd("cmd55b_gap", 8'hFF); rd("cmd55b_r1", 8'h01);
    send(48'h69_4000_0000_FF); rd("acmd41b_gap", 8'hFF); rd("acmd41b_r1", 8'h01);
    chk("acmd41b_init", 32'(bus.initialized), 32'd0);
    send(48'h77_0000_0000_FF); rd("cmd55c_gap", 8'hFF); rd("cmd55c_r1", 8'h01);
    send(48'h69_4000_0000_FF); rd("acmd41c_gap", 8'hFF); rd("acmd41c_r1", 8'h00);
    chk("acmd41c_init", 32'(bus.initialized), 32'd1);

    send(48'h7A_0000_0000_FF);
    rd("cmd58_gap", 8'hFF); rd("cmd58_r1", 8'h00); rd("ocr0", 8'hC0);
    rd("ocr1", 8'hFF); rd("ocr2", 8'h80); rd("ocr3", 8'h00);

    // CMD17 block 7
    exp_blk = 32'd7;
    snap = re_cnt;
    send(48'h51_0000_0007_FF);
    rd("rd_gap", 8'hFF); rd("rd_r1", 8'h00);
    for (int i = 0; i < 4; i++) rd("rd_nac", 8'hFF);
    rd("rd_token", 8'hFE);
    for (int i = 0; i < 512; i++) rd("rd_data", 8'(i));
    rd("rd_crc0", 8'hFF); rd("rd_crc1", 8'hFF); rd("rd_idle", 8'hFF);
    chk("rd_re_count", 32'(re_cnt - snap), 32'd512);
    chk("rd_re_bad", 32'(re_bad), 32'd0);
    chk("rd_block", bus.mem_block, 32'd7);

    // CMD24 block 3
    exp_blk = 32'd3;
    send(48'h58_0000_0003_FF);
    rd("wr_gap", 8'hFF); rd("wr_r1", 8'h00);
    xfer(8'hFF, dummy);
    xfer(8'hFE, dummy);
    for (int i = 0; i < 512; i++) xfer(8'(i) ^ 8'h5A, dummy);
    xfer(8'hAB, dummy); xfer(8'hCD, dummy);
    rd("wr_dresp", 8'h05);
    for (int i = 0; i < 8; i++) rd("wr_busy", 8'h00);
    rd("wr_idle", 8'hFF);
    chk("wr_we_count", 32'(we_cnt), 32'd512);
    chk("wr_we_bad", 32'(we_bad), 32'd0);
    chk("wr_offset_wrap", 32'(bus.mem_offset), 32'd0);

    // CMD17 aborted by cs after 100 data bytes
    exp_blk = 32'd9;
    send(48'h51_0000_0009_FF);
    rd("ab_gap", 8'hFF); rd("ab_r1", 8'h00);
    for (int i = 0; i < 4; i++) rd("ab_nac", 8'hFF);
    rd("ab_token", 8'hFE);
    for (int i = 0; i < 100; i++) rd("ab_data", 8'(i));
    bus.cs = 1'b1;
    #100;
    snap = re_cnt;
    chk("ab_miso", 32'(bus.miso), 32'd1);
    rd("ab_cs_hi0", 8'hFF); rd("ab_cs_hi1", 8'hFF); rd("ab_cs_hi2", 8'hFF);
    chk("ab_no_re", 32'(re_cnt), 32'(snap));
    chk("ab_init_kept", 32'(bus.initialized), 32'd1);
    bus.cs = 1'b0;
    #40;
    send(48'h7A_0000_0000_FF);
    rd("ab58_gap", 8'hFF); rd("ab58_r1", 8'h00); rd("ab58_ocr0", 8'hC0);
    rd("ab58_ocr1", 8'hFF); rd("ab58_ocr2", 8'h80); rd("ab58_ocr3", 8'h00);

    // back to idle, then data commands are refused
    send(48'h40_0000_0000_95);
    rd("cmd0b_gap", 8'hFF); rd("cmd0b_r1", 8'h01);
    chk("cmd0b_init", 32'(bus.initialized), 32'd0);
    snap = re_cnt;
    send(48'h51_0000_0001_FF);
    rd("noinit17_gap", 8'hFF); rd("noinit17_r1", 8'h05);
    rd("noinit17_idle0", 8'hFF); rd("noinit17_idle1", 8'hFF);
    chk("noinit17_no_re", 32'(re_cnt), 32'(snap));
    send(48'h4D_0000_0000_FF);
    rd("cmd13_gap", 8'hFF); rd("cmd13_r1", 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
